// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the two cache miss FSMs, the memory beat port
// and mem_bus_arbiter. The arbiter connects through the slave view; the
// caches and memory together form the master view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int BEATS  = 4
);
    localparam int BEAT_W = $clog2(BEATS);

    // icache refill side
    logic              ic_req_i;
    logic [ADDR_W-1:0] ic_addr_i;
    logic              ic_gnt_o;
    logic              ic_rvalid_o;
    logic [DATA_W-1:0] ic_rdata_o;
    logic              ic_last_o;

    // dcache refill / writeback side
    logic              dc_req_i;
    logic              dc_we_i;
    logic [ADDR_W-1:0] dc_addr_i;
    logic [DATA_W-1:0] dc_wdata_i;
    logic [BEAT_W-1:0] dc_beat_o;
    logic              dc_gnt_o;
    logic              dc_rvalid_o;
    logic [DATA_W-1:0] dc_rdata_o;
    logic              dc_last_o;

    // memory beat port
    logic              mem_valid_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  ic_req_i, ic_addr_i,
        output ic_gnt_o, ic_rvalid_o, ic_rdata_o, ic_last_o,
        input  dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
        output dc_beat_o, dc_gnt_o, dc_rvalid_o, dc_rdata_o, dc_last_o,
        output mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport master (
        output ic_req_i, ic_addr_i,
        input  ic_gnt_o, ic_rvalid_o, ic_rdata_o, ic_last_o,
        output dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
        input  dc_beat_o, dc_gnt_o, dc_rvalid_o, dc_rdata_o, dc_last_o,
        input  mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one beat-level memory port between icache refills and dcache
// refill/writeback bursts. dcache has fixed priority; after STARVE_MAX
// consecutive contested losses the icache is forced to win. A grant holds
// the port for a whole line of BEATS beats, one beat outstanding at a time.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int BEATS      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  bus
);
    localparam int BPB      = DATA_W / 8;
    localparam int BEAT_W   = $clog2(BEATS);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    localparam logic [ADDR_W-1:0]   OFF_MASK   = ADDR_W'(BEATS * BPB - 1);
    localparam logic [ADDR_W-1:0]   BEAT_BYTES = ADDR_W'(BPB);
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   base_r, base_s;
    logic [BEAT_W-1:0]   beat_r, beat_s;
    logic                we_r, we_s;
    logic [STARVE_W-1:0] starve_r, starve_s;
    logic                ic_gnt_r, ic_gnt_s;
    logic                dc_gnt_r, dc_gnt_s;
    logic                ic_rvalid_r, ic_rvalid_s;
    logic                dc_rvalid_r, dc_rvalid_s;
    logic                ic_last_r, ic_last_s;
    logic                dc_last_r, dc_last_s;
    logic [DATA_W-1:0]   rdata_r, rdata_s;
    logic                ic_win_s;
    logic                busy_s;

    // Arbitration in IDLE, beat sequencing and response capture in BUSY.
    always_comb begin
        state_s     = state_r;
        base_s      = base_r;
        beat_s      = beat_r;
        we_s        = we_r;
        starve_s    = starve_r;
        rdata_s     = rdata_r;
        ic_gnt_s    = 1'b0;
        dc_gnt_s    = 1'b0;
        ic_rvalid_s = 1'b0;
        dc_rvalid_s = 1'b0;
        ic_last_s   = 1'b0;
        dc_last_s   = 1'b0;
        ic_win_s    = 1'b0;

        case (state_r)
            IDLE: begin
                // icache wins when alone, or once it has lost STARVE_MAX times
                ic_win_s = bus.ic_req_i & (~bus.dc_req_i | (starve_r >= STARVE_LIM));
                if (ic_win_s) begin
                    state_s  = BUSY_I;
                    base_s   = bus.ic_addr_i & ~OFF_MASK;
                    beat_s   = {BEAT_W{1'b0}};
                    we_s     = 1'b0;
                    starve_s = {STARVE_W{1'b0}};
                    ic_gnt_s = 1'b1;
                end else if (bus.dc_req_i) begin
                    state_s  = BUSY_D;
                    base_s   = bus.dc_addr_i & ~OFF_MASK;
                    beat_s   = {BEAT_W{1'b0}};
                    we_s     = bus.dc_we_i;
                    dc_gnt_s = 1'b1;
                    // only a contested loss counts toward starvation
                    if (bus.ic_req_i) begin
                        starve_s = starve_r + STARVE_W'(1);
                    end else begin
                        starve_s = starve_r;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ack_i) begin
                    beat_s = beat_r + BEAT_W'(1);
                    if (!we_r) begin
                        rdata_s = bus.mem_rdata_i;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    if (state_r == BUSY_I) begin
                        ic_rvalid_s = 1'b1;
                        ic_last_s   = (beat_r == LAST_BEAT);
                    end else begin
                        dc_rvalid_s = ~we_r;
                        dc_last_s   = (beat_r == LAST_BEAT);
                    end
                    if (beat_r == LAST_BEAT) begin
                        state_s = IDLE;
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Burst context, starvation count and one-cycle response pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_r      <= {ADDR_W{1'b0}};
            beat_r      <= {BEAT_W{1'b0}};
            we_r        <= 1'b0;
            starve_r    <= {STARVE_W{1'b0}};
            rdata_r     <= {DATA_W{1'b0}};
            ic_gnt_r    <= 1'b0;
            dc_gnt_r    <= 1'b0;
            ic_rvalid_r <= 1'b0;
            dc_rvalid_r <= 1'b0;
            ic_last_r   <= 1'b0;
            dc_last_r   <= 1'b0;
        end else begin
            base_r      <= base_s;
            beat_r      <= beat_s;
            we_r        <= we_s;
            starve_r    <= starve_s;
            rdata_r     <= rdata_s;
            ic_gnt_r    <= ic_gnt_s;
            dc_gnt_r    <= dc_gnt_s;
            ic_rvalid_r <= ic_rvalid_s;
            dc_rvalid_r <= dc_rvalid_s;
            ic_last_r   <= ic_last_s;
            dc_last_r   <= dc_last_s;
        end
    end

    assign busy_s = (state_r != IDLE);

    // The beat port is decoded straight from registers; write data is a
    // combinational pass-through of the dcache beat selected by dc_beat_o.
    assign bus.mem_valid_o = busy_s;
    assign bus.mem_we_o    = busy_s & we_r;
    assign bus.mem_addr_o  = busy_s ? (base_r + ADDR_W'(beat_r) * BEAT_BYTES) : {ADDR_W{1'b0}};
    assign bus.mem_wdata_o = (state_r == BUSY_D) ? bus.dc_wdata_i : {DATA_W{1'b0}};
    assign bus.dc_beat_o   = (state_r == BUSY_D) ? beat_r : {BEAT_W{1'b0}};

    assign bus.ic_gnt_o    = ic_gnt_r;
    assign bus.dc_gnt_o    = dc_gnt_r;
    assign bus.ic_rvalid_o = ic_rvalid_r;
    assign bus.dc_rvalid_o = dc_rvalid_r;
    assign bus.ic_last_o   = ic_last_r;
    assign bus.dc_last_o   = dc_last_r;
    assign bus.ic_rdata_o  = rdata_r;
    assign bus.dc_rdata_o  = rdata_r;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a table of single-burst
// vectors, hand sequences for the multi-cycle corners, and a randomized
// run compared every cycle against a line-level reference model.
module tb_mem_bus_arbiter;
    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int BEATS      = 4;
    localparam int STARVE_MAX = 4;
    localparam int BPB        = DATA_W / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) bus ();

    mem_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .STARVE_MAX(STARVE_MAX)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // dcache write data: beat index in the low bits under a changing salt
    logic [31:0] wsalt = 32'h5A17_0000;
    assign bus.dc_wdata_i = {wsalt, 30'd0, bus.dc_beat_o};

    // memory environment
    int lat      = 1;   // 0 = random ack, N = ack after N valid cycles
    int wait_cnt = 0;
    bit spur     = 1'b0;
    typedef struct { logic [63:0] addr; logic [63:0] data; } wr_t;
    wr_t wlog[$];
    byte glog[$];

    // reference model: who owns the port, which line, how many beats done
    int          m_owner = 0;   // 0 none, 1 icache, 2 dcache
    logic [63:0] m_base  = 64'd0;
    int          m_beat  = 0;
    bit          m_we    = 1'b0;
    int          m_lost  = 0;   // contested icache losses in a row
    bit          m_ic_gnt, m_dc_gnt, m_ic_rv, m_dc_rv, m_ic_last, m_dc_last;
    logic [63:0] m_rdata = 64'd0;

    function automatic logic [63:0] memf(input logic [63:0] a);
        return a ^ 64'hC3A5_5A3C_0F1E_2D4B;
    endfunction

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return a - (a % 64'(BEATS * BPB));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit ic_win;
        m_ic_gnt = 1'b0; m_dc_gnt = 1'b0; m_ic_rv = 1'b0;
        m_dc_rv = 1'b0; m_ic_last = 1'b0; m_dc_last = 1'b0;
        if (rst) begin
            m_owner = 0; m_base = 64'd0; m_beat = 0; m_we = 1'b0; m_lost = 0;
        end else if (m_owner != 0) begin
            if (bus.mem_ack_i) begin
                if (m_owner == 1) begin
                    m_ic_rv   = 1'b1;
                    m_ic_last = (m_beat == BEATS - 1);
                end else begin
                    m_dc_rv   = !m_we;
                    m_dc_last = (m_beat == BEATS - 1);
                end
                if (!m_we) m_rdata = bus.mem_rdata_i;
                m_beat++;
                if (m_beat == BEATS) begin
                    m_owner = 0;
                    m_beat  = 0;
                end
            end
        end else begin
            ic_win = bus.ic_req_i && (!bus.dc_req_i || m_lost == STARVE_MAX);
            if (ic_win) begin
                m_owner = 1; m_base = line_of(bus.ic_addr_i); m_we = 1'b0;
                m_beat = 0; m_lost = 0; m_ic_gnt = 1'b1;
            end else if (bus.dc_req_i) begin
                m_owner = 2; m_base = line_of(bus.dc_addr_i); m_we = bus.dc_we_i;
                m_beat = 0; m_dc_gnt = 1'b1;
                if (bus.ic_req_i) m_lost++;
            end
        end
    endtask

    task automatic model_compare();
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        e_addr  = (m_owner != 0) ? m_base + 64'(m_beat * BPB) : 64'd0;
        e_wdata = (m_owner == 2) ? {wsalt, 30'd0, 2'(m_beat)} : 64'd0;
        check("mem_valid", 64'(bus.mem_valid_o), 64'(m_owner != 0));
        check("mem_addr", bus.mem_addr_o, e_addr);
        check("mem_we", 64'(bus.mem_we_o), 64'(m_owner != 0 && m_we));
        check("mem_wdata", bus.mem_wdata_o, e_wdata);
        check("dc_beat", 64'(bus.dc_beat_o), (m_owner == 2) ? 64'(m_beat) : 64'd0);
        check("ic_gnt", 64'(bus.ic_gnt_o), 64'(m_ic_gnt));
        check("dc_gnt", 64'(bus.dc_gnt_o), 64'(m_dc_gnt));
        check("ic_rvalid", 64'(bus.ic_rvalid_o), 64'(m_ic_rv));
        check("dc_rvalid", 64'(bus.dc_rvalid_o), 64'(m_dc_rv));
        check("ic_last", 64'(bus.ic_last_o), 64'(m_ic_last));
        check("dc_last", 64'(bus.dc_last_o), 64'(m_dc_last));
        if (m_ic_rv) check("ic_rdata", bus.ic_rdata_o, m_rdata);
        if (m_dc_rv) check("dc_rdata", bus.dc_rdata_o, m_rdata);
    endtask

    // Called at a falling edge: answer memory, step the model, move to the
    // next falling edge and compare the DUT against the model.
    task automatic tick();
        bit ack;
        ack = 1'b0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 64'd0;
        if (rst) begin
            wait_cnt = 0;
        end else if (bus.mem_valid_o) begin
            if (lat == 0) ack = ($urandom_range(2, 0) == 0);
            else          ack = (wait_cnt >= lat - 1);
            if (ack) begin
                wait_cnt        = 0;
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = memf(bus.mem_addr_o);
                if (bus.mem_we_o) wlog.push_back('{bus.mem_addr_o, bus.mem_wdata_o});
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (spur) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = 64'hDEAD_BEEF_0BAD_F00D;
            end
        end
        model_step();
        @(negedge clk);
        model_compare();
        if (bus.ic_gnt_o) glog.push_back(8'h49);
        if (bus.dc_gnt_o) glog.push_back(8'h44);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (bus.mem_valid_o && k < budget) begin
            tick();
            k++;
        end
        check("drain_timeout", 64'(bus.mem_valid_o), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit          ic_req;
        bit          dc_req;
        bit          dc_we;
        logic [63:0] ic_addr;
        logic [63:0] dc_addr;
        bit          e_ic_gnt;
        bit          e_dc_gnt;
        logic [63:0] e_addr;
        bit          e_we;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int n_last, n_rv;
        string order;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 64'h8000_0018, 64'h0, 1'b1, 1'b0, 64'h8000_0000, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 64'h0, 64'h1234_5677, 1'b0, 1'b1, 64'h1234_5660, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFE0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 64'h40, 64'h20, 1'b0, 1'b1, 64'h20, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 64'h3F, 64'h0, 1'b1, 1'b0, 64'h20, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 64'h100, 64'h2008, 1'b0, 1'b1, 64'h2000, 1'b0};

        rst = 1'b1;
        bus.ic_req_i = 1'b0; bus.ic_addr_i = 64'd0;
        bus.dc_req_i = 1'b0; bus.dc_we_i = 1'b0; bus.dc_addr_i = 64'd0;
        bus.mem_ack_i = 1'b0; bus.mem_rdata_i = 64'd0;
        @(negedge clk);
        tick();
        tick();
        check("reset_valid", 64'(bus.mem_valid_o), 64'd0);
        check("reset_addr", bus.mem_addr_o, 64'd0);
        check("reset_gnts", 64'({bus.ic_gnt_o, bus.dc_gnt_o}), 64'd0);
        rst = 1'b0;

        // table of single bursts from IDLE
        for (int i = 0; i < 6; i++) begin
            bus.ic_req_i = vecs[i].ic_req; bus.ic_addr_i = vecs[i].ic_addr;
            bus.dc_req_i = vecs[i].dc_req; bus.dc_addr_i = vecs[i].dc_addr;
            bus.dc_we_i  = vecs[i].dc_we;
            tick();
            check($sformatf("vec%0d_ic_gnt", i), 64'(bus.ic_gnt_o), 64'(vecs[i].e_ic_gnt));
            check($sformatf("vec%0d_dc_gnt", i), 64'(bus.dc_gnt_o), 64'(vecs[i].e_dc_gnt));
            check($sformatf("vec%0d_addr", i), bus.mem_addr_o, vecs[i].e_addr);
            check($sformatf("vec%0d_we", i), 64'(bus.mem_we_o), 64'(vecs[i].e_we));
            bus.ic_req_i = 1'b0; bus.dc_req_i = 1'b0;
            drain(40);
        end

        // single icache refill, ack every cycle
        bus.ic_req_i = 1'b1; bus.ic_addr_i = 64'h8000_0018;
        tick();
        check("ic_refill_gnt", 64'(bus.ic_gnt_o), 64'd1);
        bus.ic_req_i = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            check($sformatf("ic_refill_addr%0d", b), bus.mem_addr_o, 64'h8000_0000 + 64'(b * 8));
            tick();
            check($sformatf("ic_refill_rv%0d", b), 64'(bus.ic_rvalid_o), 64'd1);
            check($sformatf("ic_refill_data%0d", b), bus.ic_rdata_o, memf(64'h8000_0000 + 64'(b * 8)));
            check($sformatf("ic_refill_last%0d", b), 64'(bus.ic_last_o), 64'(b == BEATS - 1));
        end
        check("ic_refill_idle", 64'(bus.mem_valid_o), 64'd0);

        // dcache writeback with two-cycle ack latency
        lat = 2;
        wlog.delete();
        bus.dc_req_i = 1'b1; bus.dc_we_i = 1'b1; bus.dc_addr_i = 64'h1040;
        tick();
        check("wb_gnt", 64'(bus.dc_gnt_o), 64'd1);
        check("wb_we", 64'(bus.mem_we_o), 64'd1);
        bus.dc_req_i = 1'b0;
        n_last = 0; n_rv = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.dc_last_o) n_last++;
            if (bus.dc_rvalid_o) n_rv++;
        end
        check("wb_last_count", 64'(n_last), 64'd1);
        check("wb_rvalid_count", 64'(n_rv), 64'd0);
        check("wb_beats", 64'(wlog.size()), 64'(BEATS));
        for (int i = 0; i < BEATS && i < wlog.size(); i++) begin
            check($sformatf("wb_addr%0d", i), wlog[i].addr, 64'h1040 + 64'(i * 8));
            check($sformatf("wb_data%0d", i), wlog[i].data, {wsalt, 30'd0, 2'(i)});
        end
        bus.dc_we_i = 1'b0;
        lat = 1;

        // both requesters held: dcache four times, then icache, repeating
        do_reset();
        glog.delete();
        bus.ic_req_i = 1'b1; bus.ic_addr_i = 64'h4000;
        bus.dc_req_i = 1'b1; bus.dc_addr_i = 64'h6000;
        for (int k = 0; k < 200 && glog.size() < 10; k++) tick();
        bus.ic_req_i = 1'b0; bus.dc_req_i = 1'b0;
        drain(40);
        order = "DDDDIDDDDI";
        for (int i = 0; i < 10; i++) begin
            check($sformatf("starve_order%0d", i),
                  (i < glog.size()) ? 64'(glog[i]) : 64'd0, 64'(order[i]));
        end

        // back-to-back dcache bursts: exactly one idle cycle between them
        bus.dc_req_i = 1'b1; bus.dc_addr_i = 64'h3000;
        tick();
        check("b2b_first_gnt", 64'(bus.dc_gnt_o), 64'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("b2b_valid%0d", k), 64'(bus.mem_valid_o), 64'(k != 3));
        end
        check("b2b_second_gnt", 64'(bus.dc_gnt_o), 64'd1);
        bus.dc_req_i = 1'b0;
        drain(40);

        // reset in the middle of an icache burst, after the beat 1 ack
        bus.ic_req_i = 1'b1; bus.ic_addr_i = 64'h8000_0040;
        tick();
        bus.ic_req_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", 64'(bus.mem_valid_o), 64'd0);
        check("rst_mid_addr", bus.mem_addr_o, 64'd0);
        check("rst_mid_pulses", 64'({bus.ic_rvalid_o, bus.ic_last_o, bus.ic_gnt_o}), 64'd0);
        bus.ic_req_i = 1'b1;
        tick();
        check("rst_restart_gnt", 64'(bus.ic_gnt_o), 64'd1);
        check("rst_restart_addr", bus.mem_addr_o, 64'h8000_0040);
        bus.ic_req_i = 1'b0;
        drain(40);

        // spurious acks while idle are ignored
        spur = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("spur_rv%0d", k), 64'({bus.ic_rvalid_o, bus.dc_rvalid_o}), 64'd0);
        end
        spur = 1'b0;

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k % 500 == 0) lat = $urandom_range(2, 0);
            if (bus.ic_gnt_o) bus.ic_req_i = 1'b0;
            else if (!bus.ic_req_i && $urandom_range(3, 0) == 0) begin
                bus.ic_req_i  = 1'b1;
                bus.ic_addr_i = {$urandom, $urandom};
            end
            if (bus.dc_gnt_o) bus.dc_req_i = 1'b0;
            else if (!bus.dc_req_i && $urandom_range(3, 0) == 0) begin
                bus.dc_req_i  = 1'b1;
                bus.dc_we_i   = $urandom_range(1, 0) == 1;
                bus.dc_addr_i = {$urandom, $urandom};
            end
            wsalt = $urandom;
            rst   = ($urandom_range(299, 0) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single beat-level memory port between icache line refills and dcache line refill/writeback bursts.
- Sits below both caches; the memory side of each cache miss FSM talks to this block instead of the bus.
- Fixed priority to dcache, with an anti-starvation override for icache.
- Grants are held for a whole line burst of BEATS beats; one beat is outstanding at a time.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, beat data width; bytes per beat BPB = DATA_W/8
BEATS, 4, beats per cache line (power of 2, >=2)
STARVE_MAX, 4, consecutive icache losses before icache is forced to win (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset
ic_req_i  in  1  icache refill request, held until ic_gnt_o
ic_addr_i  in  ADDR_W  icache miss address
ic_gnt_o  out  1  one-cycle pulse: icache burst accepted
ic_rvalid_o  out  1  read beat valid to icache
ic_rdata_o  out  DATA_W  read beat data
ic_last_o  out  1  qualifies final beat
dc_req_i  in  1  dcache request, held until dc_gnt_o
dc_we_i  in  1  1 = writeback burst, 0 = refill
dc_addr_i  in  ADDR_W  dcache line address
dc_wdata_i  in  DATA_W  write beat data, indexed by dc_beat_o
dc_beat_o  out  clog2(BEATS)  current beat index of the active dcache burst
dc_gnt_o  out  1  one-cycle pulse: dcache burst accepted
dc_rvalid_o  out  1  read beat valid to dcache (refills only)
dc_rdata_o  out  DATA_W  read beat data
dc_last_o  out  1  final beat; also pulses on the final write ack
mem_valid_o  out  1  beat request valid
mem_we_o  out  1  beat is a write
mem_addr_o  out  ADDR_W  beat address
mem_wdata_o  out  DATA_W  write data
mem_ack_i  in  1  beat complete; rdata valid for reads
mem_rdata_i  in  DATA_W  read data

Interface: single clock clk; rst is synchronous and active-high.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Registers: base address, beat counter, we flag, starve counter.
- Reset (sync, active-high, also mid-burst): state IDLE, all outputs 0, beat counter 0, starve counter 0.
  - An in-flight beat is abandoned; memory must tolerate this.

Arbitration (IDLE only):
- If dc_req_i and ic_req_i are both set and starve counter < STARVE_MAX: dcache wins and the starve counter increments.
- If only one requester is active, that requester wins.
- An icache win clears the starve counter. When the starve counter == STARVE_MAX and ic_req_i is set, icache wins.
- On a decision, the next cycle enters BUSY_x with:
  - base = addr with the low log2(BEATS*BPB) bits cleared;
  - beat = 0;
  - we latched (icache bursts are always reads).
- The matching *_gnt_o is high for exactly the first BUSY cycle. A request still high after gnt is treated as a new request.

BUSY operation:
- mem_valid_o = 1.
- mem_addr_o = base + beat*BPB. Addresses never leave the line; no wrap is needed.
- mem_we_o = latched we; mem_wdata_o = dc_wdata_i combinationally.
- dc_beat_o = beat in BUSY_D, otherwise 0.
- On mem_ack_i:
  - beat increments next cycle;
  - mem_valid_o stays high with the new address (no bubble);
  - for reads, mem_rdata_i is registered and presented with *_rvalid_o one cycle after the ack;
  - *_last_o is set with the beat index BEATS-1 response.
- The ack on beat BEATS-1 returns the FSM to IDLE next cycle. The final response is driven during that IDLE cycle.
- A new decision can be made in that same IDLE cycle, so the minimum gap between bursts is one cycle with mem_valid_o low.
- Writes: no rvalid. dc_last_o pulses for one cycle, one cycle after the final write ack.
- mem_ack_i while mem_valid_o = 0 is ignored.
- Requester address and we changes during BUSY have no effect.
- rvalid, last and gnt are one-cycle pulses, and are 0 whenever not explicitly driven.

Test Plan:
- Single icache refill: ic_addr_i=0x8000_0018, mem acks every cycle -> ic_gnt_o pulse; mem_addr_o 0x8000_0000, 0x08, 0x10, 0x18 on consecutive cycles; 4 ic_rvalid_o pulses with matching data; ic_last_o on the 4th; FSM in IDLE after.
- Dcache writeback with 2-cycle ack latency: dc_we_i=1, addr=0x1040 -> mem_we_o=1; addresses 0x1040..0x1058; mem_wdata_o tracks dc_wdata_i for dc_beat_o=0..3; dc_last_o pulses once; no dc_rvalid_o.
- Simultaneous requests, both held continuously with STARVE_MAX=4 -> grant order D, D, D, D, I, D...; starve counter returns to 0 after the I grant.
- Back-to-back: dc_req_i held through a burst end -> exactly one IDLE cycle with mem_valid_o=0 between the final ack and the next beat 0.
- rst=1 in BUSY_I after beat 1 ack -> next cycle all outputs 0, IDLE, starve counter 0; a later request restarts at beat 0.
- Spurious mem_ack_i while IDLE -> no rvalid, no state change.
